ts_record_packer: RTL and testbench



---
 rtl/ts_record_packer.sv | 217 +++++++++++++++++++++
 tb/tb_ts_record_packer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_record_packer.sv
// Batches timestamp records and emits each batch as one big-endian framed byte packet.
// Define TS_RECORD_CHECKSUM_EN to append an XOR checksum byte after the last record.
module ts_record_packer #(
    parameter int ID_W         = 4,
    parameter int TS_W         = 64,
    parameter int RECS_PER_PKT = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [TS_W-1:0] in_start_ts,
    input  logic [TS_W-1:0] in_end_ts,
    input  logic [TS_W-1:0] in_delta,
    output logic [7:0]      m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last,
    output logic [15:0]     pkt_count
);
    localparam int REC_BYTES = 1 + 3 * (TS_W / 8);
    localparam int REC_BITS  = 8 * REC_BYTES;
    localparam int CW        = $clog2(RECS_PER_PKT + 1);
    localparam int IW        = (RECS_PER_PKT > 1) ? $clog2(RECS_PER_PKT) : 1;
    localparam int BW        = $clog2(REC_BYTES);
    localparam logic [CW-1:0] FULL    = CW'(RECS_PER_PKT);
    localparam logic [31:0]   TO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] LAST_B  = BW'(REC_BYTES - 1);

`ifdef TS_RECORD_CHECKSUM_EN
    typedef enum logic [1:0] {COLLECT = 2'd0, HDR = 2'd1, REC = 2'd2, TRL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {COLLECT = 2'd0, HDR = 2'd1, REC = 2'd2} state_t;
`endif

    state_t              state_r;
    logic [CW-1:0]       count_r;
    logic [31:0]         timer_r;
    logic [7:0]          seq_r;
    logic [15:0]         pkt_count_r;
    logic                in_ready_r;
    logic                m_valid_r;
    logic                m_last_r;
    logic [7:0]          m_data_r;
    logic [1:0]          hidx_r;
    logic [IW-1:0]       ridx_r;
    logic [BW-1:0]       bcnt_r;
    logic [REC_BITS-1:0] sh_r;

    logic [ID_W-1:0] id_buf    [RECS_PER_PKT];
    logic [TS_W-1:0] start_buf [RECS_PER_PKT];
    logic [TS_W-1:0] end_buf   [RECS_PER_PKT];
    logic [TS_W-1:0] delta_buf [RECS_PER_PKT];

    logic                accept_s;
    logic [CW-1:0]       count_nxt_s;
    logic                last_rec_s;
    logic [IW-1:0]       load_idx_s;
    logic [REC_BITS-1:0] load_word_s;
    logic [7:0]          hdr_next_s;

    function automatic logic [REC_BITS-1:0] rec_word(input logic [IW-1:0] idx);
        return {8'(id_buf[idx]), start_buf[idx], end_buf[idx], delta_buf[idx]};
    endfunction

    assign accept_s    = in_valid && in_ready_r;
    assign count_nxt_s = count_r + CW'(accept_s);
    assign last_rec_s  = (ridx_r == IW'(count_r - CW'(1)));

    // Next header byte and the record word to load when a record starts
    always_comb begin
        hdr_next_s  = 8'h00;
        load_idx_s  = (state_r == REC) ? ridx_r + IW'(1) : '0;
        load_word_s = rec_word(load_idx_s);
        case (hidx_r)
            2'd0:    hdr_next_s = seq_r;
            2'd1:    hdr_next_s = 8'(count_r);
            default: hdr_next_s = 8'h00;
        endcase
    end

    // Record buffer, written in arrival order; stale entries are never read
    always_ff @(posedge clk) begin
        if (accept_s) begin
            id_buf[count_r[IW-1:0]]    <= in_id;
            start_buf[count_r[IW-1:0]] <= in_start_ts;
            end_buf[count_r[IW-1:0]]   <= in_end_ts;
            delta_buf[count_r[IW-1:0]] <= in_delta;
        end
    end

`ifdef TS_RECORD_CHECKSUM_EN
    logic [7:0] csum_r;

    // Running XOR of every byte handed downstream in the current packet
    always_ff @(posedge clk) begin
        if (!rst_n || state_r == COLLECT) begin
            csum_r <= 8'h00;
        end else if (m_valid_r && m_ready) begin
            csum_r <= csum_r ^ m_data_r;
        end
    end
`endif

    // Collect/flush sequencer; m_data always holds the byte currently offered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= COLLECT;
            count_r     <= '0;
            timer_r     <= 32'd0;
            seq_r       <= 8'h00;
            pkt_count_r <= 16'h0000;
            in_ready_r  <= 1'b0;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            m_data_r    <= 8'h00;
            hidx_r      <= 2'd0;
            ridx_r      <= '0;
            bcnt_r      <= '0;
            sh_r        <= '0;
        end else begin
            case (state_r)
                COLLECT: begin
                    count_r <= count_nxt_s;
                    if (accept_s && count_r == '0) begin
                        timer_r <= 32'd0;
                    end else if (count_r != '0) begin
                        timer_r <= timer_r + 32'd1;
                    end
                    if (count_nxt_s == FULL || (count_r != '0 && timer_r == TO_LAST)) begin
                        state_r    <= HDR;
                        hidx_r     <= 2'd0;
                        m_valid_r  <= 1'b1;
                        m_data_r   <= 8'hA5;
                        m_last_r   <= 1'b0;
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                HDR: begin
                    if (m_ready) begin
                        if (hidx_r != 2'd3) begin
                            hidx_r   <= hidx_r + 2'd1;
                            m_data_r <= hdr_next_s;
                        end else begin
                            state_r  <= REC;
                            ridx_r   <= '0;
                            bcnt_r   <= '0;
                            m_data_r <= load_word_s[REC_BITS-1 -: 8];
                            sh_r     <= load_word_s << 8;
                        end
                    end
                end
                REC: begin
                    if (m_ready) begin
                        if (bcnt_r != LAST_B) begin
                            bcnt_r   <= bcnt_r + BW'(1);
                            m_data_r <= sh_r[REC_BITS-1 -: 8];
                            sh_r     <= sh_r << 8;
`ifndef TS_RECORD_CHECKSUM_EN
                            m_last_r <= last_rec_s && (bcnt_r == LAST_B - BW'(1));
`endif
                        end else if (!last_rec_s) begin
                            ridx_r   <= ridx_r + IW'(1);
                            bcnt_r   <= '0;
                            m_data_r <= load_word_s[REC_BITS-1 -: 8];
                            sh_r     <= load_word_s << 8;
                        end else begin
`ifdef TS_RECORD_CHECKSUM_EN
                            state_r  <= TRL;
                            m_data_r <= csum_r ^ m_data_r;
                            m_last_r <= 1'b1;
`else
                            state_r     <= COLLECT;
                            m_valid_r   <= 1'b0;
                            m_last_r    <= 1'b0;
                            m_data_r    <= 8'h00;
                            seq_r       <= seq_r + 8'd1;
                            pkt_count_r <= pkt_count_r + 16'd1;
                            count_r     <= '0;
                            timer_r     <= 32'd0;
                            in_ready_r  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef TS_RECORD_CHECKSUM_EN
                TRL: begin
                    if (m_ready) begin
                        state_r     <= COLLECT;
                        m_valid_r   <= 1'b0;
                        m_last_r    <= 1'b0;
                        m_data_r    <= 8'h00;
                        seq_r       <= seq_r + 8'd1;
                        pkt_count_r <= pkt_count_r + 16'd1;
                        count_r     <= '0;
                        timer_r     <= 32'd0;
                        in_ready_r  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign pkt_count = pkt_count_r;
endmodule

// File: tb/tb_ts_record_packer.sv
// Directed bench for ts_record_packer: table of batch vectors plus reset, back-pressure and wrap sequences.
module tb_ts_record_packer;
    localparam int ID_W = 4;
    localparam int TS_W = 64;
    localparam int RECS = 4;
    localparam int TO   = 16;
`ifdef TS_RECORD_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [ID_W-1:0] in_id = '0;
    logic [TS_W-1:0] in_start_ts = '0;
    logic [TS_W-1:0] in_end_ts = '0;
    logic [TS_W-1:0] in_delta = '0;
    logic [7:0]      m_data;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic            m_last;
    logic [15:0]     pkt_count;

    ts_record_packer #(.ID_W(ID_W), .TS_W(TS_W), .RECS_PER_PKT(RECS), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_delta(in_delta),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nrec;
        bit          stall;
        logic [7:0]  seq;
        int          len;
        logic [15:0] pkts;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pkt_done = 0;
    int stall_err = 0;
    int irdy_err = 0;
    bit stall_en = 1'b0;
    logic [7:0]      rx_q[$];
    bit              rx_last_q[$];
    logic [ID_W-1:0] e_id[$];
    logic [TS_W-1:0] e_st[$];
    logic [TS_W-1:0] e_en[$];
    logic [TS_W-1:0] e_dl[$];
    logic [7:0]      got[0:127];
    int              got_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Byte monitor: captures handshakes, stall stability and in_ready during emission
    initial begin
        logic [7:0] pd;
        bit pl;
        bit ps;
        pd = 8'h00;
        pl = 1'b0;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ps && (!m_valid || m_data !== pd || m_last !== pl)) stall_err++;
                if (m_valid && in_ready) irdy_err++;
                if (m_valid && m_ready) begin
                    rx_q.push_back(m_data);
                    rx_last_q.push_back(m_last);
                    if (m_last) pkt_done++;
                end
                ps = m_valid && !m_ready;
                pd = m_data;
                pl = m_last;
            end else begin
                ps = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_rec(input int k, output int acc);
        int w;
        in_id       = k[ID_W-1:0];
        in_start_ts = 64'(k) * 64'h10;
        in_end_ts   = 64'(k) * 64'h10 + 64'd5;
        in_delta    = 64'd5;
        in_valid    = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 2000);
        check("send_accept", in_ready, 1);
        if (in_ready) begin
            @(posedge clk);
            #1;
            e_id.push_back(in_id);
            e_st.push_back(in_start_ts);
            e_en.push_back(in_end_ts);
            e_dl.push_back(in_delta);
        end
        in_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_pkts(input int target);
        int w;
        w = 0;
        while (pkt_done < target && w < 3000) begin
            @(posedge clk);
            w++;
        end
        check("pkt_wait", pkt_done >= target, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] want_seq, input int n);
        logic [7:0] want[$];
        logic [7:0] x;
        bit lst;
        int len;
        int bad_at;
        bit last_ok;
        bit done;
        want.push_back(8'hA5);
        want.push_back(want_seq);
        want.push_back(8'(n));
        want.push_back(8'h00);
        for (int r = 0; r < n; r++) begin
            logic [TS_W-1:0] s, e, d;
            logic [ID_W-1:0] id;
            if (e_id.size() != 0) begin
                id = e_id.pop_front();
                s  = e_st.pop_front();
                e  = e_en.pop_front();
                d  = e_dl.pop_front();
                want.push_back(8'(id));
                for (int b = TS_W / 8 - 1; b >= 0; b--) want.push_back(s[8*b +: 8]);
                for (int b = TS_W / 8 - 1; b >= 0; b--) want.push_back(e[8*b +: 8]);
                for (int b = TS_W / 8 - 1; b >= 0; b--) want.push_back(d[8*b +: 8]);
            end
        end
        if (CK != 0) begin
            x = 8'h00;
            foreach (want[i]) x = x ^ want[i];
            want.push_back(x);
        end
        len = 0;
        bad_at = -1;
        last_ok = 1'b1;
        done = 1'b0;
        while (!done && rx_q.size() > 0) begin
            x   = rx_q.pop_front();
            lst = rx_last_q.pop_front();
            if (len < 128) got[len] = x;
            if (bad_at < 0 && (len >= want.size() || x !== want[len])) bad_at = len;
            if (lst != (len == want.size() - 1)) last_ok = 1'b0;
            len++;
            done = lst;
        end
        got_len = len;
        check({tag, " len"}, len, want.size());
        check({tag, " seq"}, got[1], want_seq);
        check({tag, " first_bad_byte"}, bad_at, -1);
        check({tag, " last_pos"}, last_ok, 1);
    endtask

    initial begin
        vec_t vecs[5];
        int kk;
        int acc;
        int base;
        int w;
        int id5;

        vecs[0] = '{4, 1'b0, 8'h00, 104 + CK, 16'd1};
        vecs[1] = '{1, 1'b0, 8'h01, 29 + CK, 16'd2};
        vecs[2] = '{4, 1'b1, 8'h02, 104 + CK, 16'd3};
        vecs[3] = '{3, 1'b1, 8'h03, 79 + CK, 16'd4};
        vecs[4] = '{2, 1'b0, 8'h04, 54 + CK, 16'd5};

        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst m_valid", m_valid, 0);
        check("rst m_last", m_last, 0);
        check("rst m_data", m_data, 0);
        check("rst pkt_count", pkt_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", in_ready, 1);

        kk = 1;
        for (int v = 0; v < 5; v++) begin
            int first_acc;
            stall_en = vecs[v].stall;
            base = pkt_done;
            first_acc = 0;
            for (int r = 0; r < vecs[v].nrec; r++) begin
                send_rec(kk, acc);
                if (r == 0) first_acc = acc;
                kk++;
            end
            if (vecs[v].nrec == RECS) begin
                check("fill_latency", m_valid, 1);
            end else begin
                w = 0;
                while (!m_valid && w < 200) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check("timeout_latency", cyc - first_acc, TO);
            end
            wait_pkts(base + 1);
            check_pkt($sformatf("vec%0d", v), vecs[v].seq, vecs[v].nrec);
            check("pkt_len", got_len, vecs[v].len);
            check("pkt_count", pkt_count, vecs[v].pkts);
            if (v == 0) begin
                check("hdr byte0", got[0], 8'hA5);
                check("hdr N", got[2], 8'h04);
                check("hdr byte3", got[3], 8'h00);
                check("rec0 id", got[4], 8'h01);
                check("rec0 start lsb", got[12], 8'h10);
                check("rec0 end lsb", got[20], 8'h15);
                check("rec0 delta lsb", got[28], 8'h05);
            end
            check("stall_stable", stall_err, 0);
        end
        stall_en = 1'b0;

        // in_valid held high across two packets
        base = pkt_done;
        id5 = (kk + 4) % 16;
        for (int r = 0; r < 8; r++) begin
            send_rec(kk, acc);
            kk++;
        end
        wait_pkts(base + 2);
        check_pkt("cont1", 8'h05, 4);
        check_pkt("cont2", 8'h06, 4);
        check("5th record heads next packet", got[4], id5);
        check("in_ready low while emitting", irdy_err, 0);

        // Reset in the middle of a full packet
        base = pkt_done;
        for (int r = 0; r < 4; r++) begin
            send_rec(kk, acc);
            kk++;
        end
        w = 0;
        while (rx_q.size() < 50 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("reached byte 50", rx_q.size() >= 50, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst m_valid", m_valid, 0);
        check("midrst m_last", m_last, 0);
        check("midrst in_ready", in_ready, 0);
        check("midrst pkt_count", pkt_count, 0);
        rst_n = 1'b1;
        check("in_ready still low", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready rises", in_ready, 1);
        check("abandoned packet has no last", pkt_done, base);
        rx_q.delete();
        rx_last_q.delete();
        e_id.delete();
        e_st.delete();
        e_en.delete();
        e_dl.delete();
        send_rec(kk, acc);
        kk++;
        wait_pkts(base + 1);
        check_pkt("post_rst", 8'h00, 1);
        check("post_rst pkt_count", pkt_count, 1);

        // seq and pkt_count wrap over 257 timeout packets from reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 257; i++) begin
            base = pkt_done;
            send_rec(kk, acc);
            kk++;
            wait_pkts(base + 1);
            check_pkt("wrap", i[7:0], 1);
            if (i == 255) check("pkt_count 0x100", pkt_count, 16'h0100);
        end
        check("pkt_count 0x101", pkt_count, 16'h0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
